// File: rtl/addsub_pkg.sv
// Shared definitions for the add/sub issue stage.
//  - op_e      : opcode encoding carried through the pipeline
//  - FLG_*     : bit positions inside the {N,Z,C,V} flag nibble
//  - helpers   : decode whether an op inverts B or takes carry-in from flag_c
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBC = 2'b11
  } op_e;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  // Subtracts feed ~B into the adder (two's complement via cin).
  function automatic logic op_inverts_b(op_e op);
    return (op == OP_SUB) || (op == OP_SBC);
  endfunction

  // ADC/SBC take their carry-in from the architectural carry flag.
  function automatic logic op_uses_carry(op_e op);
    return (op == OP_ADC) || (op == OP_SBC);
  endfunction

endpackage

// File: rtl/sync_fifo2.sv
// Two-entry synchronous FIFO.
//  clk, rst_n : clock, synchronous active-low reset (empties the FIFO)
//  clr        : synchronous clear, empties the FIFO; wins over push/pop
//  push/wdata : write request; ignored when full
//  pop        : read request; ignored when empty
//  rdata      : head entry (valid when count != 0)
//  count      : number of stored entries, 0..2
module sync_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         push_ok, pop_ok;

  always_comb begin
    push_ok  = push & (count_q != 2'd2);
    pop_ok   = pop  & (count_q != 2'd0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/addsub_issue_stage.sv
// Issue/retire stage around an external 32-bit adder.
//  Front  : in_valid/in_ready/in_op/in_a/in_b/in_tag into a 2-entry FIFO.
//  Issue  : add_a/add_b registered from the FIFO head (B inverted for SUB/SBC),
//           add_cin combinational from the issued op and flag_c.
//  Retire : add_s/add_cout/add_ovf captured into out_result/out_flags with
//           out_tag; out_valid/out_ready hand the result to the consumer.
//  flag_c : architectural carry, updated when a result is captured.
//  flush  : empties FIFO, issue and result stages; keeps flag_c and data.
// Handshake rule for both ports: a transfer happens at a rising edge where
// valid and ready are both 1; a valid producer holds its payload until then.
module addsub_issue_stage
  import addsub_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int TAG_W      = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_cout,
  input  logic             add_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       out_flags,
  output logic             flag_c
);

  localparam int ENTRY_W = 2 + 2 * WIDTH + TAG_W;

  logic [1:0]         fifo_count;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic               push, pop, retire_load;
  op_e                head_op;
  logic [WIDTH-1:0]   head_a, head_b;
  logic [TAG_W-1:0]   head_tag;
  logic [3:0]         flags_new;

  logic               iss_valid_q, iss_valid_d;
  op_e                iss_op_q, iss_op_d;
  logic [TAG_W-1:0]   iss_tag_q, iss_tag_d;
  logic [WIDTH-1:0]   add_a_q, add_a_d;
  logic [WIDTH-1:0]   add_b_q, add_b_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_result_q, out_result_d;
  logic [TAG_W-1:0]   out_tag_q, out_tag_d;
  logic [3:0]         out_flags_q, out_flags_d;
  logic               flag_c_q, flag_c_d;

  // Ready depends only on the registered count, never on out_ready.
  assign in_ready = (fifo_count < 2'(FIFO_DEPTH)) & ~flush & rst_n;
  assign push     = in_valid & in_ready;

  sync_fifo2 #(.W(ENTRY_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (push),
    .wdata ({in_op, in_a, in_b, in_tag}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count)
  );

  assign head_op  = op_e'(fifo_rdata[ENTRY_W-1 -: 2]);
  assign head_a   = fifo_rdata[ENTRY_W-3 -: WIDTH];
  assign head_b   = fifo_rdata[TAG_W +: WIDTH];
  assign head_tag = fifo_rdata[TAG_W-1:0];

  // Carry-in reads flag_c live, so an ADC/SBC issued on the same edge that
  // its predecessor retires already sees the new carry.
  always_comb begin
    case (iss_op_q)
      OP_ADD:  add_cin = 1'b0;
      OP_SUB:  add_cin = 1'b1;
      default: add_cin = op_uses_carry(iss_op_q) & flag_c_q;
    endcase
  end

  always_comb begin
    flags_new        = '0;
    flags_new[FLG_N] = add_s[WIDTH-1];
    flags_new[FLG_Z] = (add_s == '0);
    flags_new[FLG_C] = add_cout;
    flags_new[FLG_V] = add_ovf;
  end

  always_comb begin
    retire_load  = iss_valid_q & (~out_valid_q | out_ready);
    pop          = (~iss_valid_q | retire_load) & (fifo_count != 2'd0) & ~flush;
    iss_valid_d  = iss_valid_q;
    iss_op_d     = iss_op_q;
    iss_tag_d    = iss_tag_q;
    add_a_d      = add_a_q;
    add_b_d      = add_b_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;
    out_flags_d  = out_flags_q;
    flag_c_d     = flag_c_q;
    if (flush) begin
      // Flush wins over any same-edge retire or issue; data is left as is.
      iss_valid_d = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      if (retire_load) begin
        out_valid_d  = 1'b1;
        out_result_d = add_s;
        out_tag_d    = iss_tag_q;
        out_flags_d  = flags_new;
        flag_c_d     = add_cout;
        iss_valid_d  = 1'b0;
      end else if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
      if (pop) begin
        iss_valid_d = 1'b1;
        iss_op_d    = head_op;
        iss_tag_d   = head_tag;
        add_a_d     = head_a;
        add_b_d     = op_inverts_b(head_op) ? ~head_b : head_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      iss_valid_q  <= 1'b0;
      iss_op_q     <= OP_ADD;
      iss_tag_q    <= '0;
      add_a_q      <= '0;
      add_b_q      <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
      out_flags_q  <= '0;
      flag_c_q     <= 1'b0;
    end else begin
      iss_valid_q  <= iss_valid_d;
      iss_op_q     <= iss_op_d;
      iss_tag_q    <= iss_tag_d;
      add_a_q      <= add_a_d;
      add_b_q      <= add_b_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
      out_flags_q  <= out_flags_d;
      flag_c_q     <= flag_c_d;
    end
  end

  assign add_a      = add_a_q;
  assign add_b      = add_b_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;
  assign out_flags  = out_flags_q;
  assign flag_c     = flag_c_q;

endmodule

// File: tb/tb_addsub_issue_stage.sv
// Bench for addsub_issue_stage with a behavioural 32-bit adder attached.
module tb_addsub_issue_stage;

  logic        clk, rst_n, flush;
  logic        in_valid, in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a, in_b;
  logic [3:0]  in_tag;
  logic [31:0] add_a, add_b, add_s;
  logic        add_cin, add_cout, add_ovf;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_tag, out_flags;
  logic        flag_c;

  int n_checks = 0;
  int n_pass   = 0;
  logic [39:0] exp_q[$];

  addsub_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout), .add_ovf(add_ovf),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_flags(out_flags), .flag_c(flag_c)
  );

  // Adder stand-in: sum, carry-out and signed overflow of A + B + Cin.
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};
  assign add_ovf = (add_a[31] == add_b[31]) && (add_s[31] != add_a[31]);

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // ---------------- driver tasks ----------------
  // Pushes the expectation, offers the op and returns right after the
  // accepting rising edge (in_valid is still high; caller drops or reuses it).
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] tag, input logic [31:0] res, input logic [3:0] flg);
    int n;
    exp_q.push_back({res, tag, flg});
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    n = 0;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) chk("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Four ops used by both the stall and the flush scenarios.
  task automatic send_burst4(input logic [3:0] t0);
    send(2'b00, 32'd1, 32'd2, t0, 32'd3, 4'b0000);
    send(2'b01, 32'd10, 32'd3, t0 + 4'd1, 32'd7, 4'b0010);
    send(2'b00, 32'h80000000, 32'h80000000, t0 + 4'd2, 32'd0, 4'b0111);
    send(2'b01, 32'd3, 32'd10, t0 + 4'd3, 32'hFFFFFFF9, 4'b1000);
    idle();
  endtask

  task automatic send_flush_burst();
    send(2'b00, 32'hFFFFFFFF, 32'd2, 4'd4, 32'd1, 4'b0010);
    send(2'b00, 32'd1, 32'd1, 4'd5, 32'd2, 4'b0000);
    send(2'b00, 32'd1, 32'd1, 4'd6, 32'd2, 4'b0000);
    send(2'b00, 32'd1, 32'd1, 4'd7, 32'd2, 4'b0000);
    idle();
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", {out_result, out_tag, out_flags}, 64'hDEAD);
      end else begin
        chk("result_tag_flags", {24'd0, out_result, out_tag, out_flags}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = 2'b00;
    in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_result", 64'(out_result), 64'd0);
    chk("rst_out_tag_flags", {56'd0, out_tag, out_flags}, 64'd0);
    chk("rst_add_ab", {add_a, add_b}, 64'd0);
    chk("rst_flag_c", 64'(flag_c), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    // 1: overflow into the sign bit, two-edge latency
    send(2'b00, 32'h7FFFFFFF, 32'd1, 4'hA, 32'h80000000, 4'b1001);
    idle();
    chk("lat_edge0", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("lat_edge1", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("lat_edge2", 64'(out_valid), 64'd1);
    repeat (3) @(negedge clk);
    chk("flag_c_after_add", 64'(flag_c), 64'd0);

    // 3: carry produced by ADD feeds the back-to-back ADC
    send(2'b00, 32'hFFFFFFFF, 32'd1, 4'hD, 32'd0, 4'b0110);
    send(2'b10, 32'd0, 32'd0, 4'hE, 32'd1, 4'b0000);
    idle();
    @(negedge clk);
    chk("b2b_first", {59'd0, out_valid, out_tag}, {59'd0, 1'b1, 4'hD});
    @(negedge clk);
    chk("b2b_second", {59'd0, out_valid, out_tag}, {59'd0, 1'b1, 4'hE});
    repeat (3) @(negedge clk);

    // 2: SUB equal operands, then SBC with carry-in from flag
    send(2'b01, 32'd5, 32'd5, 4'hB, 32'd0, 4'b0110);
    idle();
    repeat (4) @(negedge clk);
    chk("flag_c_after_sub", 64'(flag_c), 64'd1);
    send(2'b11, 32'd0, 32'd0, 4'hC, 32'd0, 4'b0110);
    idle();
    @(negedge clk);
    chk("sbc_add_cin", 64'(add_cin), 64'd1);
    chk("sbc_add_b", 64'(add_b), 64'hFFFFFFFF);
    repeat (4) @(negedge clk);

    // 4: consumer stalls for 6 cycles with 4 ops offered
    out_ready = 1'b0;
    fork send_burst4(4'd0); join_none
    repeat (5) @(negedge clk);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    chk("stall_out_head", {59'd0, out_valid, out_tag}, {59'd0, 1'b1, 4'd0});
    chk("stall_add_ab_a", {add_a, add_b}, {32'd10, 32'hFFFFFFFC});
    @(negedge clk);
    chk("stall_add_ab_b", {add_a, add_b}, {32'd10, 32'hFFFFFFFC});
    chk("stall_add_cin", 64'(add_cin), 64'd1);
    out_ready = 1'b1;
    repeat (8) @(negedge clk);
    chk("stall_drained", 64'(exp_q.size()), 64'd0);

    // 5: flush with every stage full
    out_ready = 1'b0;
    fork send_flush_burst(); join_none
    repeat (5) @(negedge clk);
    chk("pre_flush_full", {62'd0, out_valid, in_ready}, {62'd0, 1'b1, 1'b0});
    chk("pre_flush_flag_c", 64'(flag_c), 64'd1);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("post_flush", {61'd0, out_valid, in_ready, flag_c}, {61'd0, 1'b0, 1'b1, 1'b1});
    exp_q.delete();
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_flush_idle", 64'(out_valid), 64'd0);
    send(2'b10, 32'd4, 32'd5, 4'd8, 32'd10, 4'b0000);
    idle();
    repeat (3) @(negedge clk);
    send(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd9, 32'hFFFFFFFE, 4'b1010);
    idle();
    repeat (4) @(negedge clk);
    chk("flush_drained", 64'(exp_q.size()), 64'd0);

    // 6: reset in the middle of a stream
    fork
      begin
        send(2'b00, 32'd1, 32'd1, 4'hA, 32'd2, 4'b0000);
        send(2'b00, 32'd2, 32'd2, 4'hB, 32'd4, 4'b0000);
        idle();
      end
    join_none
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("midrst_out", {28'd0, out_valid, out_result, out_tag}, 64'd0);
    chk("midrst_flags", {59'd0, out_flags, flag_c}, 64'd0);
    chk("midrst_add_ab", {add_a, add_b}, 64'd0);
    exp_q.delete();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_no_stale", 64'(out_valid), 64'd0);
    send(2'b10, 32'd7, 32'd8, 4'hC, 32'd15, 4'b0000);
    idle();
    repeat (4) @(negedge clk);
    chk("final_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
